// File: rtl/obj_line_buffer_pp.sv
// Ping-pong OBJ line buffer: the sprite renderer fills one bank while the
// compositor drains the other. Render writes resolve OBJ priority per pixel
// and can mark OBJ-window pixels. A swap exchanges the banks and starts a
// sweep that clears the new render bank one entry per cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | render bank open for writes (blocked only on a swap cycle)
// SWEEP  | clearing render-bank entry sc each cycle; writes blocked
module obj_line_buffer_pp #(
    parameter int DATA_W        = 20,
    parameter int PRIO_W        = 2,
    parameter int COLS          = 240,
    parameter int COL_W         = 8,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic              clk_sys_i,
    input  logic              rst_b_i,
    input  logic              swap_i,
    input  logic              we_i,
    output logic              wready_o,
    input  logic [COL_W-1:0]  wcol_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PRIO_W-1:0] wprio_i,
    input  logic              wtransparent_i,
    input  logic              wwin_i,
    input  logic              rd_en_i,
    input  logic [COL_W-1:0]  rcol_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [PRIO_W-1:0] rprio_o,
    output logic              rvalid_o,
    output logic              rwin_o,
    output logic              disp_bank_o,
    output logic              busy_o,
    output logic              overrun_o
);

    // Entry layout: {valid, win, prio, data}; an empty entry is all zero.
    localparam int               ENT_W    = DATA_W + PRIO_W + 2;
    localparam int               VLD_BIT  = ENT_W - 1;
    localparam int               WIN_BIT  = ENT_W - 2;
    localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  sc_q, sc_d;
    logic              disp_bank_q, disp_bank_d;
    logic              overrun_q, overrun_d;
    logic [ENT_W-1:0]  rd_ent_q, rd_ent_d;

    logic [ENT_W-1:0]  mem_q [2][COLS];

    logic              render_bank;
    logic              sweep_clr;
    logic              wr_fire;
    logic              wr_in_range;
    logic [COL_W-1:0]  wr_idx;
    logic [ENT_W-1:0]  wr_cur;
    logic              wr_en;
    logic [ENT_W-1:0]  wr_ent;
    logic              rd_hit;
    logic [COL_W-1:0]  rd_idx;

    assign render_bank = ~disp_bank_q;

    // Sweep sequencing and bank swap; a swap always restarts the sweep at 0.
    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        disp_bank_d = disp_bank_q;
        overrun_d   = 1'b0;
        sweep_clr   = 1'b0;
        wready_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wready_o = rst_b_i & ~swap_i;
            end
            ST_SWEEP: begin
                sweep_clr = 1'b1;
                if (sc_q == LAST_COL) begin
                    state_d = ST_IDLE;
                    sc_d    = '0;
                end else begin
                    sc_d = sc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (swap_i) begin
            disp_bank_d = ~disp_bank_q;
            sc_d        = '0;
            state_d     = ST_SWEEP;
            overrun_d   = (state_q == ST_SWEEP);
        end
    end

    // Render-side write: priority resolve, window mark, transparent/out-of-range drop.
    always_comb begin
        wr_fire     = we_i & wready_o;
        wr_in_range = (wcol_i < COLS_C);
        wr_idx      = wr_in_range ? wcol_i : '0;
        wr_cur      = mem_q[render_bank][wr_idx];
        wr_en       = 1'b0;
        wr_ent      = wr_cur;
        if (wr_fire && wr_in_range && !wtransparent_i) begin
            if (wwin_i) begin
                wr_en           = 1'b1;
                wr_ent[WIN_BIT] = 1'b1;
            end else if (!wr_cur[VLD_BIT] || (wprio_i < wr_cur[DATA_W +: PRIO_W])) begin
                // Equal priority keeps the stored pixel (earlier OAM index wins).
                wr_en  = 1'b1;
                wr_ent = {1'b1, wr_cur[WIN_BIT], wprio_i, wdata_i};
            end
        end
    end

    // Display-side read: out-of-range or idle reads return an empty entry.
    always_comb begin
        rd_hit   = rd_en_i & (rcol_i < COLS_C);
        rd_idx   = rd_hit ? rcol_i : '0;
        rd_ent_d = rd_hit ? mem_q[disp_bank_q][rd_idx] : '0;
    end

    // Control and read-output registers.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            state_q     <= ST_IDLE;
            sc_q        <= '0;
            disp_bank_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_ent_q    <= '0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            disp_bank_q <= disp_bank_d;
            overrun_q   <= overrun_d;
            rd_ent_q    <= rd_ent_d;
        end
    end

    // Bank storage; sweep/write hit the render bank, read-clear the display bank.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[b][c] <= '0;
                end
            end
        end else begin
            if (sweep_clr) begin
                mem_q[render_bank][sc_q] <= '0;
            end
            if (wr_en) begin
                mem_q[render_bank][wr_idx] <= wr_ent;
            end
            if (CLEAR_ON_READ && rd_hit) begin
                mem_q[disp_bank_q][rd_idx] <= '0;
            end
        end
    end

    assign rdata_o     = rd_ent_q[DATA_W-1:0];
    assign rprio_o     = rd_ent_q[DATA_W +: PRIO_W];
    assign rvalid_o    = rd_ent_q[VLD_BIT];
    assign rwin_o      = rd_ent_q[WIN_BIT];
    assign disp_bank_o = disp_bank_q;
    assign busy_o      = (state_q == ST_SWEEP);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_obj_line_buffer_pp.sv
// Directed bench for obj_line_buffer_pp with a read-result scoreboard.
module tb_obj_line_buffer_pp;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        swap, we, wready, wtransparent, wwin, rd_en;
    logic [7:0]  wcol, rcol;
    logic [19:0] wdata, rdata;
    logic [1:0]  wprio, rprio;
    logic        rvalid, rwin, disp_bank, busy, overrun;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    always #5 clk = ~clk;

    obj_line_buffer_pp dut (
        .clk_sys_i      (clk),
        .rst_b_i        (rst_b),
        .swap_i         (swap),
        .we_i           (we),
        .wready_o       (wready),
        .wcol_i         (wcol),
        .wdata_i        (wdata),
        .wprio_i        (wprio),
        .wtransparent_i (wtransparent),
        .wwin_i         (wwin),
        .rd_en_i        (rd_en),
        .rcol_i         (rcol),
        .rdata_o        (rdata),
        .rprio_o        (rprio),
        .rvalid_o       (rvalid),
        .rwin_o         (rwin),
        .disp_bank_o    (disp_bank),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    function automatic logic [31:0] mk(input logic [19:0] d, input logic [1:0] p,
                                       input logic v, input logic w);
        return {8'h00, d, p, v, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic read_col(input logic [7:0] col, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        rd_en = 1'b1;
        rcol  = col;
        sb.push_back('{tag, exp});
        tick();
        rd_en = 1'b0;
        e = sb.pop_front();
        check(e.tag, {8'h00, rdata, rprio, rvalid, rwin}, e.exp);
    endtask

    task automatic wr(input logic [7:0] col, input logic [19:0] d, input logic [1:0] p,
                      input logic win, input logic tr);
        int n = 0;
        we = 1'b1; wcol = col; wdata = d; wprio = p; wwin = win; wtransparent = tr;
        #1;
        while (!wready && n < 400) begin
            tick();
            n++;
        end
        check("wr_wready", {31'd0, wready}, 32'd1);
        tick();
        we = 1'b0; wwin = 1'b0; wtransparent = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("busy_settle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lo, bz, ov;
        rst_b = 1'b0; swap = 1'b0; we = 1'b0; wtransparent = 1'b0; wwin = 1'b0;
        rd_en = 1'b0; wcol = '0; rcol = '0; wdata = '0; wprio = '0;

        // Reset state
        repeat (3) tick();
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_disp", {31'd0, disp_bank}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rd", {8'h00, rdata, rprio, rvalid, rwin}, 32'd0);
        rst_b = 1'b1;
        tick();
        for (int c = 0; c < 240; c++) read_col(8'(c), 32'd0, "rst_read_all");

        // Priority resolution and window/transparent handling into bank 0
        do_swap();
        check("disp_after_swap1", {31'd0, disp_bank}, 32'd1);
        wait_idle();
        wr(8'd5, 20'h00123, 2'd2, 1'b0, 1'b0);
        wr(8'd5, 20'h00456, 2'd1, 1'b0, 1'b0);
        wr(8'd5, 20'h00789, 2'd1, 1'b0, 1'b0);
        wr(8'd10, 20'h00000, 2'd3, 1'b1, 1'b0);
        wr(8'd10, 20'h00AAA, 2'd0, 1'b0, 1'b0);
        wr(8'd11, 20'h00BBB, 2'd0, 1'b0, 1'b1);
        do_swap();
        check("disp_after_swap2", {31'd0, disp_bank}, 32'd0);
        read_col(8'd5, mk(20'h00456, 2'd1, 1'b1, 1'b0), "prio_resolve");
        read_col(8'd5, 32'd0, "clear_on_read");
        read_col(8'd10, mk(20'h00AAA, 2'd0, 1'b1, 1'b1), "win_plus_opaque");
        read_col(8'd11, 32'd0, "transparent_drop");
        wait_idle();

        // Swap-to-write gap with we held
        swap = 1'b1; we = 1'b1; wcol = 8'd20; wdata = 20'h0F0F0; wprio = 2'd3;
        #1;
        check("wready_on_swap", {31'd0, wready}, 32'd0);
        tick();
        swap = 1'b0;
        lo = 0; bz = 0;
        while (!wready && lo < 400) begin
            if (busy) bz++;
            lo++;
            tick();
        end
        check("wready_low_cycles", lo, 240);
        check("busy_cycles", bz, 240);
        check("busy_after_sweep", {31'd0, busy}, 32'd0);
        tick();
        we = 1'b0;

        // Fill render bank 0 completely, plus an out-of-range write
        for (int c = 0; c < 240; c++) wr(8'(c), 20'h10000 | 20'(c), 2'd1, 1'b0, 1'b0);
        wr(8'd250, 20'h0DEAD, 2'd0, 1'b0, 1'b0);
        do_swap();
        check("disp_after_fill_swap", {31'd0, disp_bank}, 32'd0);
        wait_idle();

        // Overrun: second swap 100 cycles after the first
        check("overrun_idle", {31'd0, overrun}, 32'd0);
        do_swap();
        ov = 0;
        for (int i = 0; i < 99; i++) begin
            if (overrun) ov++;
            tick();
        end
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check("overrun_pulse_now", {31'd0, overrun}, 32'd1);
        bz = 0;
        while (busy && bz < 400) begin
            if (overrun) ov++;
            bz++;
            tick();
        end
        check("overrun_count", ov, 1);
        check("restart_busy_cycles", bz, 240);
        check("disp_after_overrun", {31'd0, disp_bank}, 32'd0);

        // Out-of-range reads, then the partially swept bank
        read_col(8'd240, 32'd0, "rd_col240");
        read_col(8'd255, 32'd0, "rd_col255");
        for (int c = 0; c < 240; c++) begin
            if (c < 100) read_col(8'(c), 32'd0, "partial_swept");
            else read_col(8'(c), mk(20'h10000 | 20'(c), 2'd1, 1'b1, 1'b0), "partial_kept");
        end
        read_col(8'd150, 32'd0, "reread_cleared");

        // Reset mid-sweep with content in the new display bank
        wr(8'd7, 20'h07777, 2'd2, 1'b0, 1'b0);
        do_swap();
        check("disp_before_reset", {31'd0, disp_bank}, 32'd1);
        repeat (50) tick();
        check("busy_mid_sweep", {31'd0, busy}, 32'd1);
        rst_b = 1'b0;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_disp", {31'd0, disp_bank}, 32'd0);
        check("midrst_wready", {31'd0, wready}, 32'd0);
        rst_b = 1'b1;
        tick();
        for (int c = 0; c < 240; c++) read_col(8'(c), 32'd0, "midrst_bank0");
        do_swap();
        check("midrst_swap_disp", {31'd0, disp_bank}, 32'd1);
        read_col(8'd7, 32'd0, "midrst_bank1_col7");
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/obj_line_buffer_pp.md
# obj_line_buffer_pp

Parametrised ping-pong OBJ line buffer between the sprite renderer and the line compositor. The renderer writes one bank per scanline with per-pixel OBJ priority resolution and OBJ-window marking, while the compositor reads the other bank. Entries clear on read, and a hardware sweep clears the new render bank after each swap. It replaces single-cycle bulk clears with a sweep and makes width, depth and priority width configurable.

## Interface
- DATA_W, 20, pixel payload width (colour/palette data plus attribute bits)
- PRIO_W, 2, OBJ priority width; lower value wins
- COLS, 240, visible columns per line
- COL_W, 8, column index width; must satisfy 2^COL_W > COLS
- CLEAR_ON_READ, 1, when 1 a read clears the entry it reads
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- swap  in  1  single-cycle pulse at line start; exchanges render and display banks
- we  in  1  write request into render bank
- wready  out  1  write accepted this cycle when we & wready
- wcol  in  COL_W  write column
- wdata  in  DATA_W  pixel payload
- wprio  in  PRIO_W  pixel priority
- wtransparent  in  1  pixel transparent; request is accepted but the entry is unchanged
- wwin  in  1  OBJ-window pixel; sets entry window bit only
- rd_en  in  1  read request from display bank
- rcol  in  COL_W  read column
- rdata  out  DATA_W  registered read payload
- rprio  out  PRIO_W  registered read priority
- rvalid  out  1  registered: entry held an opaque pixel
- rwin  out  1  registered: entry window bit
- disp_bank  out  1  index of the current display bank
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse: swap arrived while sweep was busy

## Operation
- Each of the two banks holds COLS entries of {valid, win, prio, data}. Empty entry = all zero.
- Render bank = ~disp_bank; display bank = disp_bank.
- FSM has two states.
  - IDLE: wready = ~swap.
  - SWEEP: wready = 0; a counter sc clears render-bank entry sc, one per cycle, from 0 to COLS-1. The clear of COLS-1 returns the FSM to IDLE.
- swap, in any state: toggles disp_bank, sets sc = 0, enters SWEEP. If the state was already SWEEP, overrun pulses; the partially cleared bank becomes the display bank as-is.
- Accepted write, wcol < COLS, wtransparent = 0:
  - wwin = 1: set the win bit only; valid, prio and data are untouched.
  - wwin = 0: write {1, win kept, wprio, wdata} if entry valid = 0 or wprio < stored prio. On equal priority the stored entry wins, so the earlier OAM index keeps its pixel.
- Accepted write with wtransparent = 1 or wcol >= COLS: no state change; the handshake still completes.
- Read with rd_en = 1 and rcol < COLS: the display-bank entry goes to the output registers. If CLEAR_ON_READ = 1, the entry is zeroed on the same edge.
- Read with rcol >= COLS, or rd_en = 0: output registers load zero. No clear occurs.
- Reads and sweep/writes always target different banks, so no port conflicts exist.
- A swap and a read in the same cycle: the read uses the pre-swap display bank.

## Timing
- Reset (reset = 0 at an edge): both banks zeroed, disp_bank = 0, state IDLE, sc = 0. Outputs rdata/rprio/rvalid/rwin/busy/overrun = 0; wready = 0 while reset = 0.
- Write latency: an entry updates on the edge where we & wready. A read of that entry after the next swap and sweep sees it.
- Read latency: 1 cycle. rdata is valid on the cycle after rd_en.
- busy = 1 from the cycle after swap through the cycle that clears column COLS-1, i.e. COLS cycles. wready rises on the following cycle.
- The swap-to-first-accepted-write gap is COLS+1 cycles.
- Back-to-back swaps: each swap restarts the sweep. overrun pulses on every swap that lands while busy.
- Reset asserted mid-sweep aborts the sweep; all state returns to reset values.

## Test plan
- Reset, then read cols 0..239 -> rvalid = 0, rdata = 0 for all; busy = 0, disp_bank = 0.
- swap; wait for busy = 0. Write col 5 {prio 2, data 0x00123}, then col 5 {prio 1, data 0x00456}, then col 5 {prio 1, data 0x00789}. swap, read col 5 -> rdata = 0x00456, rprio = 1, rvalid = 1. Read col 5 again -> rvalid = 0 (cleared on read).
- Write col 10 with wwin = 1, then col 10 opaque {prio 0, data 0x00AAA}. Write col 11 with wtransparent = 1. After swap, read col 10 -> rwin = 1, rvalid = 1, rdata = 0x00AAA; read col 11 -> rvalid = 0.
- swap, then hold we = 1 -> wready = 0 for exactly 240 cycles, busy high 240 cycles, first accepted write on cycle 241 after swap.
- Second swap 100 cycles after the first -> overrun pulses once and the sweep restarts at 0. Entries 0..99 of the new display bank read zero; entries 100..239 keep their contents.
- Read with rcol = 240 and rcol = 255 -> rdata = 0, rvalid = 0, no entry altered. Pull reset low mid-sweep -> busy = 0, disp_bank = 0, all entries read zero.
